vga_scan_gen: RTL and testbench

//  Drives the VGA raster: pixel/line counters, hsync/vsync, and the x/y scan coordinates and

---
 rtl/vga_scan_gen.sv | 148 ++++++++++++++
 tb/tb_vga_scan_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_gen.sv
// VGA raster generator: pixel/line counters, registered syncs and colour, frame-rate delt animation.
// Define VGA_DELT_BOUNCE_EN to make delt bounce between 0 and DELT_MAX instead of wrapping to 0.
module vga_scan_gen #(
  parameter int   H_VIS     = 800,
  parameter int   H_FP      = 40,
  parameter int   H_SYNC    = 128,
  parameter int   H_BP      = 88,
  parameter int   V_VIS     = 600,
  parameter int   V_FP      = 1,
  parameter int   V_SYNC    = 4,
  parameter int   V_BP      = 23,
  parameter logic SYNC_POL  = 1'b1,
  parameter int   DELT_STEP = 2,
  parameter int   DELT_MAX  = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        hit,
  input  logic [8:0]  fg_color,
  input  logic [8:0]  bg_color,
  output logic [10:0] x,
  output logic [10:0] y,
  output logic [10:0] delt,
  output logic        hsync,
  output logic        vsync,
  output logic [2:0]  r,
  output logic [2:0]  g,
  output logic [2:0]  b,
  output logic        frame_tick
);

  localparam int          H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int          V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_C = 11'(H_VIS);
  localparam logic [10:0] V_VIS_C = 11'(V_VIS);
  localparam logic [10:0] HS_BEG  = 11'(H_VIS + H_FP);
  localparam logic [10:0] HS_END  = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG  = 11'(V_VIS + V_FP);
  localparam logic [10:0] VS_END  = 11'(V_VIS + V_FP + V_SYNC);
  localparam logic [11:0] STEP12  = 12'(DELT_STEP);
  localparam logic [11:0] MAX12   = 12'(DELT_MAX);
`ifdef VGA_DELT_BOUNCE_EN
  localparam logic [10:0] STEP11  = 11'(DELT_STEP);
  localparam logic [10:0] MAX11   = 11'(DELT_MAX);
`endif

  logic [10:0] r_x;
  logic [10:0] r_y;
  logic [10:0] r_delt;
  logic        w_x_last;
  logic        w_y_last;
  logic        w_active;
  logic        w_hs_on;
  logic        w_vs_on;
  logic [11:0] w_delt_up;
  logic [10:0] w_delt_nxt;
  logic [8:0]  r_rgb_p1;
  logic        r_hsync_p1;
  logic        r_vsync_p1;
`ifdef VGA_DELT_BOUNCE_EN
  logic        r_dir_down;
  logic        w_dir_down_nxt;
`endif

  // Stage 0: decode from the live counters
  assign w_x_last = (r_x == H_LAST);
  assign w_y_last = (r_y == V_LAST);
  assign w_active = (r_x < H_VIS_C) && (r_y < V_VIS_C);
  assign w_hs_on  = (r_x >= HS_BEG) && (r_x < HS_END);
  assign w_vs_on  = (r_y >= VS_BEG) && (r_y < VS_END);

  // 12-bit sum keeps the overflow compare honest near the top of the 11-bit range
  always_comb begin
    w_delt_up  = {1'b0, r_delt} + STEP12;
    w_delt_nxt = r_delt;
`ifdef VGA_DELT_BOUNCE_EN
    w_dir_down_nxt = r_dir_down;
    if (r_dir_down) begin
      if ({1'b0, r_delt} < STEP12) begin
        w_delt_nxt     = '0;
        w_dir_down_nxt = 1'b0;
      end else begin
        w_delt_nxt = r_delt - STEP11;
      end
    end else if (w_delt_up > MAX12) begin
      w_delt_nxt     = MAX11;
      w_dir_down_nxt = 1'b1;
    end else begin
      w_delt_nxt = w_delt_up[10:0];
    end
`else
    if (w_delt_up > MAX12) begin
      w_delt_nxt = '0;
    end else begin
      w_delt_nxt = w_delt_up[10:0];
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_x    <= '0;
      r_y    <= '0;
      r_delt <= '0;
`ifdef VGA_DELT_BOUNCE_EN
      r_dir_down <= 1'b0;
`endif
    end else begin
      r_x <= w_x_last ? 11'd0 : r_x + 11'd1;
      if (w_x_last) begin
        r_y <= w_y_last ? 11'd0 : r_y + 11'd1;
      end
      if (frame_tick && en) begin
        r_delt <= w_delt_nxt;
`ifdef VGA_DELT_BOUNCE_EN
        r_dir_down <= w_dir_down_nxt;
`endif
      end
    end
  end

  // Stage 1: colour and syncs registered together from the same x/y
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rgb_p1   <= '0;
      r_hsync_p1 <= ~SYNC_POL;
      r_vsync_p1 <= ~SYNC_POL;
    end else begin
      r_rgb_p1   <= (w_active && en) ? (hit ? fg_color : bg_color) : 9'd0;
      r_hsync_p1 <= w_hs_on ? SYNC_POL : ~SYNC_POL;
      r_vsync_p1 <= w_vs_on ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign x          = r_x;
  assign y          = r_y;
  assign delt       = r_delt;
  assign frame_tick = w_x_last && w_y_last;
  assign hsync      = r_hsync_p1;
  assign vsync      = r_vsync_p1;
  assign r          = r_rgb_p1[8:6];
  assign g          = r_rgb_p1[5:3];
  assign b          = r_rgb_p1[2:0];

endmodule

// File: tb/tb_vga_scan_gen.sv
// Scoreboard bench for vga_scan_gen on a shrunken 16x10 raster (8x6 visible) so many frames fit.
// Expectations are keyed to an absolute cycle count; a monitor pops and compares them on negedges.
module tb_vga_scan_gen;

  localparam int T0 = 3;             // cycle at which the first reset ends (pixel 0 of frame 0)
  localparam int T1 = T0 + 20060;    // cycle at which the mid-frame reset ends
  localparam int S_X = 0, S_Y = 1, S_DELT = 2, S_RGB = 3, S_HS = 4, S_VS = 5, S_FT = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b1;
  logic        hit = 1'b1;
  logic [8:0]  fg_color = 9'h1C0;
  logic [8:0]  bg_color = 9'h007;
  logic [10:0] x, y, delt;
  logic        hsync, vsync, frame_tick;
  logic [2:0]  r, g, b;

  int tcyc   = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int    t;
    int    sel;
    int    val;
    string name;
  } exp_t;
  exp_t q[$];

  vga_scan_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_VIS(6), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1), .DELT_STEP(2), .DELT_MAX(200)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .hit(hit),
    .fg_color(fg_color), .bg_color(bg_color),
    .x(x), .y(y), .delt(delt),
    .hsync(hsync), .vsync(vsync),
    .r(r), .g(g), .b(b),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  function automatic logic [31:0] actual(int sel);
    case (sel)
      S_X:     return {21'd0, x};
      S_Y:     return {21'd0, y};
      S_DELT:  return {21'd0, delt};
      S_RGB:   return {23'd0, r, g, b};
      S_HS:    return {31'd0, hsync};
      S_VS:    return {31'd0, vsync};
      default: return {31'd0, frame_tick};
    endcase
  endfunction

  task automatic expect_at(input int t, input int sel, input int val, input string name);
    exp_t e;
    e.t = t; e.sel = sel; e.val = val; e.name = name;
    q.push_back(e);
  endtask

  task automatic wait_t(input int t);
    while (tcyc < t) @(negedge clk);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].t == tcyc) begin
          logic [31:0] act;
          act = actual(q[i].sel);
          checks++;
          if (act !== 32'(q[i].val)) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", q[i].name, tcyc, act, q[i].val);
          end
          q.delete(i);
        end
      end
    end
  end

  initial begin
    // reset state, colour path, syncs and frame boundary of frame 0
    expect_at(T0 + 0,   S_X,    0,      "rst_x");
    expect_at(T0 + 0,   S_Y,    0,      "rst_y");
    expect_at(T0 + 0,   S_DELT, 0,      "rst_delt");
    expect_at(T0 + 0,   S_RGB,  0,      "rst_rgb");
    expect_at(T0 + 0,   S_HS,   0,      "rst_hsync");
    expect_at(T0 + 0,   S_VS,   0,      "rst_vsync");
    expect_at(T0 + 0,   S_FT,   0,      "rst_tick");
    expect_at(T0 + 1,   S_X,    1,      "x_step");
    expect_at(T0 + 1,   S_RGB,  'h1C0, "rgb_fg_00");
    expect_at(T0 + 5,   S_RGB,  'h1C0, "rgb_fg_x4");
    expect_at(T0 + 6,   S_RGB,  'h007, "rgb_bg_x5");
    expect_at(T0 + 7,   S_RGB,  'h1C0, "rgb_fg_x6");
    expect_at(T0 + 8,   S_RGB,  'h1C0, "rgb_last_vis");
    expect_at(T0 + 9,   S_RGB,  0,      "rgb_hblank");
    expect_at(T0 + 10,  S_HS,   0,      "hs_before");
    expect_at(T0 + 11,  S_HS,   1,      "hs_first");
    expect_at(T0 + 13,  S_HS,   1,      "hs_last");
    expect_at(T0 + 14,  S_HS,   0,      "hs_after");
    expect_at(T0 + 15,  S_X,    15,     "x_last");
    expect_at(T0 + 16,  S_X,    0,      "x_wrap");
    expect_at(T0 + 16,  S_Y,    1,      "y_inc");
    expect_at(T0 + 32,  S_X,    0,      "x_wrap2");
    expect_at(T0 + 97,  S_RGB,  0,      "rgb_vblank0");
    expect_at(T0 + 98,  S_RGB,  0,      "rgb_vblank1");
    expect_at(T0 + 112, S_VS,   0,      "vs_before");
    expect_at(T0 + 113, S_VS,   1,      "vs_first");
    expect_at(T0 + 144, S_VS,   1,      "vs_last");
    expect_at(T0 + 145, S_VS,   0,      "vs_after");
    expect_at(T0 + 158, S_FT,   0,      "tick_early");
    expect_at(T0 + 159, S_FT,   1,      "tick");
    expect_at(T0 + 159, S_Y,    9,      "y_last");
    expect_at(T0 + 159, S_X,    15,     "x_last_frame");
    expect_at(T0 + 160, S_X,    0,      "frame_x0");
    expect_at(T0 + 160, S_Y,    0,      "frame_y0");
    expect_at(T0 + 160, S_DELT, 2,      "delt_f1");
    expect_at(T0 + 8005,  S_DELT, 100,  "delt_f50");
    expect_at(T0 + 16005, S_DELT, 200,  "delt_max");
    expect_at(T0 + 16165, S_DELT, 0,    "delt_wrap");
    expect_at(T0 + 16325, S_DELT, 2,    "delt_after_wrap");
    wait_t(T0);
    checks++;
    if (x !== 11'd0) begin
      errors++;
      $display("FAIL direct_rst_x: got %0h", x);
    end
    checks++;
    if ({r, g, b} !== 9'd0) begin
      errors++;
      $display("FAIL direct_rst_rgb: got %0h", {r, g, b});
    end
    rst = 1'b0;
    wait_t(T0 + 5);
    checks++;
    if (x !== 11'd5) begin
      errors++;
      $display("FAIL direct_x5: got %0h", x);
    end
    checks++;
    if ({r, g, b} !== 9'h1C0) begin
      errors++;
      $display("FAIL direct_rgb_x4: got %0h", {r, g, b});
    end
    hit = 1'b0;
    wait_t(T0 + 6);
    checks++;
    if ({r, g, b} !== 9'h007) begin
      errors++;
      $display("FAIL direct_rgb_x5: got %0h", {r, g, b});
    end
    hit = 1'b1;

    // en low across three frame ticks starting with delt=40
    expect_at(T0 + 19362, S_RGB,  'h1C0, "en_last_on");
    expect_at(T0 + 19363, S_RGB,  0,      "en_off_rgb");
    expect_at(T0 + 19500, S_DELT, 40,     "en_off_delt0");
    expect_at(T0 + 19842, S_RGB,  0,      "en_off_rgb3");
    expect_at(T0 + 19845, S_DELT, 40,     "en_off_delt3");
    expect_at(T0 + 19851, S_HS,   1,      "en_off_hs");
    expect_at(T0 + 19995, S_DELT, 40,     "en_on_pre_tick");
    expect_at(T0 + 20002, S_RGB,  'h1C0, "en_on_rgb");
    expect_at(T0 + 20005, S_DELT, 42,     "en_on_delt");
    wait_t(T0 + 19362);
    en = 1'b0;
    wait_t(T0 + 19900);
    en = 1'b1;

    // reset pulsed mid-frame while hsync is asserted
    expect_at(T0 + 20059, S_X,    11, "pre_rst_x");
    expect_at(T0 + 20059, S_Y,    3,  "pre_rst_y");
    expect_at(T0 + 20059, S_HS,   1,  "pre_rst_hs");
    expect_at(T1,         S_X,    0,  "mid_rst_x");
    expect_at(T1,         S_Y,    0,  "mid_rst_y");
    expect_at(T1,         S_DELT, 0,  "mid_rst_delt");
    expect_at(T1,         S_RGB,  0,  "mid_rst_rgb");
    expect_at(T1,         S_HS,   0,  "mid_rst_hs");
    expect_at(T1,         S_VS,   0,  "mid_rst_vs");
    expect_at(T1 + 1,     S_X,    1,  "post_rst_x");
    expect_at(T1 + 1,     S_RGB,  'h1C0, "post_rst_rgb");
    expect_at(T1 + 113,   S_VS,   1,  "post_rst_vs");
    expect_at(T1 + 159,   S_FT,   1,  "post_rst_tick");
    expect_at(T1 + 160,   S_DELT, 2,  "post_rst_delt");
    wait_t(T0 + 20059);
    rst = 1'b1;
    wait_t(T1);
    checks++;
    if ((x !== 11'd0) || (y !== 11'd0)) begin
      errors++;
      $display("FAIL direct_mid_rst_xy: got %0h,%0h", x, y);
    end
    checks++;
    if (delt !== 11'd0) begin
      errors++;
      $display("FAIL direct_mid_rst_delt: got %0h", delt);
    end
    rst = 1'b0;
    wait_t(T1 + 170);

    while (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s: never compared, expected %0h at cyc %0d", q[0].name, q[0].val, q[0].t);
      void'(q.pop_front());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
